// File: rtl/word_pack_pkg.sv
// Shared types for the byte-to-word packer: the packed word, its int view,
// and the padded frame handed to the downstream consumer.
package word_pack_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned FRAME_W        = 40;

  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
  } foo_bytes_t;

  typedef union packed {
    foo_bytes_t bytes;
    int         i;
  } foo_t;

  typedef struct packed {
    logic [4:0] padding_0;
    foo_t       foo;
    logic [2:0] padding_1;
  } bar_t;

  typedef logic [FRAME_W-1:0] frame_raw_t;

  typedef enum logic {
    ST_EMPTY,
    ST_FILL
  } fill_state_t;

  function automatic foo_bytes_t put_byte(input foo_bytes_t w, input logic [1:0] slot,
                                          input logic [7:0] b);
    foo_bytes_t r;
    r = w;
    unique case (slot)
      2'd0: r.b0 = b;
      2'd1: r.b1 = b;
      2'd2: r.b2 = b;
      default: r.b3 = b;
    endcase
    return r;
  endfunction

  // Slots at or beyond the real byte count take the fill value.
  function automatic foo_bytes_t pad_tail(input foo_bytes_t w, input logic [2:0] nbytes,
                                          input logic [7:0] pad);
    logic [31:0] r;
    r = w;
    for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
      if (k >= 32'(nbytes)) r[31-8*k -: 8] = pad;
    end
    return foo_bytes_t'(r);
  endfunction

endpackage

// File: rtl/byte_word_packer_if.sv
// Byte-stream input and framed-word output of the packer, grouped as one bundle.
interface byte_word_packer_if import word_pack_pkg::*; #(
  parameter int unsigned CNT_W = 16
) ();

  logic             in_valid_i;
  logic             in_ready_o;
  logic [7:0]       in_data_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  bar_t             out_frame_o;
  logic [31:0]      out_word_o;
  logic             out_partial_o;
  logic [2:0]       out_nbytes_o;
  logic [CNT_W-1:0] word_cnt_o;

  modport slave (
    input  in_valid_i, in_data_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_frame_o, out_word_o,
           out_partial_o, out_nbytes_o, word_cnt_o
  );

  modport master (
    output in_valid_i, in_data_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_frame_o, out_word_o,
           out_partial_o, out_nbytes_o, word_cnt_o
  );

endinterface

// File: rtl/word_out_reg.sv
// One-entry valid/ready output register for a framed word plus its metadata.
module word_out_reg import word_pack_pkg::*; (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  bar_t       frame_i,
  input  logic       partial_i,
  input  logic [2:0] nbytes_i,
  input  logic       ready_i,
  output logic       valid_o,
  output bar_t       frame_o,
  output logic       partial_o,
  output logic [2:0] nbytes_o,
  output logic       free_o
);

  logic       valid_q;
  bar_t       frame_q;
  logic       partial_q;
  logic [2:0] nbytes_q;

  assign free_o = !valid_q || ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      frame_q   <= '0;
      partial_q <= 1'b0;
      nbytes_q  <= '0;
    end else if (load_i) begin
      valid_q   <= 1'b1;
      frame_q   <= frame_i;
      partial_q <= partial_i;
      nbytes_q  <= nbytes_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o   = valid_q;
  assign frame_o   = frame_q;
  assign partial_o = partial_q;
  assign nbytes_o  = nbytes_q;

endmodule

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 4-byte words (first byte in the MSB), with flush of
// partial words, a stall-tolerant pending flush, and an emitted-word counter.
module byte_word_packer import word_pack_pkg::*; #(
  parameter logic [7:0]  PAD_BYTE = 8'h00,
  parameter int unsigned CNT_W    = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  byte_word_packer_if.slave bus
);

  fill_state_t      state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  foo_bytes_t       asm_q, asm_d;
  logic             hold_q, hold_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic       out_free, out_valid, in_ready, byte_acc, flush_req, load;
  logic [2:0] n_after;
  foo_bytes_t asm_w;
  bar_t       frame_d, out_frame;
  logic       partial_d;
  logic [2:0] nbytes_d;

  assign in_ready = (cnt_q != 2'd3 && !hold_q) || out_free;
  assign byte_acc = bus.in_valid_i && in_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_EMPTY;
      cnt_q      <= '0;
      asm_q      <= '0;
      hold_q     <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      hold_q     <= hold_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    hold_d     = hold_q;
    word_cnt_d = word_cnt_q;
    load       = 1'b0;
    frame_d    = '0;

    asm_w     = byte_acc ? put_byte(asm_q, cnt_q, bus.in_data_i) : asm_q;
    n_after   = {1'b0, cnt_q} + {2'b00, byte_acc};
    flush_req = (bus.flush_i || hold_q) && (state_q == ST_FILL || byte_acc);

    frame_d.foo.bytes = pad_tail(asm_w, n_after, PAD_BYTE);
    partial_d         = (n_after != 3'(BYTES_PER_WORD));
    nbytes_d          = n_after;

    // A flush that meets a stalled output parks the partial word in place and
    // blocks input until the output register frees up.
    if (n_after == 3'(BYTES_PER_WORD) || flush_req) begin
      if (out_free) begin
        load   = 1'b1;
        cnt_d  = '0;
        asm_d  = '0;
        hold_d = 1'b0;
      end else begin
        hold_d = 1'b1;
        cnt_d  = n_after[1:0];
        asm_d  = asm_w;
      end
    end else begin
      cnt_d = n_after[1:0];
      asm_d = asm_w;
    end

    state_d = (cnt_d == 2'd0) ? ST_EMPTY : ST_FILL;

    if (out_valid && bus.out_ready_i) word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  word_out_reg u_out (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (load),
    .frame_i   (frame_d),
    .partial_i (partial_d),
    .nbytes_i  (nbytes_d),
    .ready_i   (bus.out_ready_i),
    .valid_o   (out_valid),
    .frame_o   (out_frame),
    .partial_o (bus.out_partial_o),
    .nbytes_o  (bus.out_nbytes_o),
    .free_o    (out_free)
  );

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_frame_o = out_frame;
  assign bus.out_word_o  = out_frame.foo.i;
  assign bus.word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed, table-driven bench for byte_word_packer, with a narrow-counter,
// non-zero-pad second instance sharing the same stimulus.
module tb_byte_word_packer;
  import word_pack_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  byte_word_packer_if #(.CNT_W(16)) bus  ();
  byte_word_packer_if #(.CNT_W(2))  bus2 ();

  byte_word_packer #(.PAD_BYTE(8'h00), .CNT_W(16)) dut (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus)
  );

  byte_word_packer #(.PAD_BYTE(8'hA5), .CNT_W(2)) dut2 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus2)
  );

  assign bus2.in_valid_i  = bus.in_valid_i;
  assign bus2.in_data_i   = bus.in_data_i;
  assign bus2.flush_i     = bus.flush_i;
  assign bus2.out_ready_i = bus.out_ready_i;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        f;
    logic        r;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_word;
    logic        e_part;
    logic [2:0]  e_nb;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic f, input logic r,
                     input logic e_rdy, input logic e_ov, input logic [31:0] e_word,
                     input logic e_part, input logic [2:0] e_nb, input logic [15:0] e_cnt);
    vec_t x;
    x.v = v; x.d = d; x.f = f; x.r = r;
    x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_word = e_word;
    x.e_part = e_part; x.e_nb = e_nb; x.e_cnt = e_cnt;
    vt.push_back(x);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic r);
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.flush_i     = f;
    bus.out_ready_i = r;
  endtask

  function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [2:0] nb,
                                           input logic [7:0] pad);
    logic [31:0] r;
    r = w;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k >= 32'(nb)) r[31-8*k -: 8] = pad;
    end
    return r;
  endfunction

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    //  v  d      f  r   rdy ov word          part nb cnt
    add(1, 8'h10, 0, 1,  1,  0, 32'h00000000, 0,   0, 0);
    add(1, 8'h11, 0, 1,  1,  0, 32'h00000000, 0,   0, 0);
    add(1, 8'h13, 0, 1,  1,  0, 32'h00000000, 0,   0, 0);
    add(1, 8'h17, 0, 1,  1,  0, 32'h00000000, 0,   0, 0);
    add(1, 8'h21, 0, 1,  1,  1, 32'h10111317, 0,   4, 0);
    add(1, 8'h22, 0, 1,  1,  0, 32'h10111317, 0,   4, 1);
    add(1, 8'h23, 0, 1,  1,  0, 32'h10111317, 0,   4, 1);
    add(1, 8'h24, 0, 1,  1,  0, 32'h10111317, 0,   4, 1);
    add(0, 8'h00, 0, 1,  1,  1, 32'h21222324, 0,   4, 1);
    add(0, 8'h00, 0, 1,  1,  0, 32'h21222324, 0,   4, 2);
    add(1, 8'hAA, 0, 1,  1,  0, 32'h21222324, 0,   4, 2);
    add(1, 8'hBB, 0, 1,  1,  0, 32'h21222324, 0,   4, 2);
    add(0, 8'h00, 1, 1,  1,  0, 32'h21222324, 0,   4, 2);
    add(0, 8'h00, 0, 1,  1,  1, 32'hAABB0000, 1,   2, 2);
    add(0, 8'h00, 1, 1,  1,  0, 32'hAABB0000, 1,   2, 3);
    add(0, 8'h00, 0, 1,  1,  0, 32'hAABB0000, 1,   2, 3);
    add(1, 8'h31, 0, 0,  1,  0, 32'hAABB0000, 1,   2, 3);
    add(1, 8'h32, 0, 0,  1,  0, 32'hAABB0000, 1,   2, 3);
    add(1, 8'h33, 0, 0,  1,  0, 32'hAABB0000, 1,   2, 3);
    add(1, 8'h34, 0, 0,  1,  0, 32'hAABB0000, 1,   2, 3);
    add(1, 8'h41, 0, 0,  1,  1, 32'h31323334, 0,   4, 3);
    add(1, 8'h42, 0, 0,  1,  1, 32'h31323334, 0,   4, 3);
    add(1, 8'h43, 0, 0,  1,  1, 32'h31323334, 0,   4, 3);
    add(1, 8'h44, 0, 0,  0,  1, 32'h31323334, 0,   4, 3);
    add(1, 8'h44, 0, 0,  0,  1, 32'h31323334, 0,   4, 3);
    add(1, 8'h44, 0, 1,  1,  1, 32'h31323334, 0,   4, 3);
    add(1, 8'h51, 0, 1,  1,  1, 32'h41424344, 0,   4, 4);
    add(1, 8'h52, 0, 1,  1,  0, 32'h41424344, 0,   4, 5);
    add(1, 8'h53, 0, 1,  1,  0, 32'h41424344, 0,   4, 5);
    add(1, 8'h54, 0, 1,  1,  0, 32'h41424344, 0,   4, 5);
    add(0, 8'h00, 0, 1,  1,  1, 32'h51525354, 0,   4, 5);
    add(0, 8'h00, 0, 1,  1,  0, 32'h51525354, 0,   4, 6);
    add(1, 8'h61, 0, 1,  1,  0, 32'h51525354, 0,   4, 6);
    add(1, 8'h62, 0, 1,  1,  0, 32'h51525354, 0,   4, 6);
    add(1, 8'h63, 0, 1,  1,  0, 32'h51525354, 0,   4, 6);
    add(1, 8'h64, 1, 1,  1,  0, 32'h51525354, 0,   4, 6);
    add(0, 8'h00, 0, 1,  1,  1, 32'h61626364, 0,   4, 6);
    add(0, 8'h00, 0, 1,  1,  0, 32'h61626364, 0,   4, 7);
    add(1, 8'h71, 0, 0,  1,  0, 32'h61626364, 0,   4, 7);
    add(1, 8'h72, 0, 0,  1,  0, 32'h61626364, 0,   4, 7);
    add(1, 8'h73, 0, 0,  1,  0, 32'h61626364, 0,   4, 7);
    add(1, 8'h74, 0, 0,  1,  0, 32'h61626364, 0,   4, 7);
    add(1, 8'h81, 0, 0,  1,  1, 32'h71727374, 0,   4, 7);
    add(0, 8'h00, 1, 0,  1,  1, 32'h71727374, 0,   4, 7);
    add(1, 8'h82, 0, 0,  0,  1, 32'h71727374, 0,   4, 7);
    add(1, 8'h82, 1, 0,  0,  1, 32'h71727374, 0,   4, 7);
    add(0, 8'h00, 0, 1,  1,  1, 32'h71727374, 0,   4, 7);
    add(0, 8'h00, 0, 1,  1,  1, 32'h81000000, 1,   1, 8);
    add(0, 8'h00, 0, 1,  1,  0, 32'h81000000, 1,   1, 9);
    add(1, 8'h91, 1, 1,  1,  0, 32'h81000000, 1,   1, 9);
    add(0, 8'h00, 0, 1,  1,  1, 32'h91000000, 1,   1, 9);
    add(0, 8'h00, 0, 1,  1,  0, 32'h91000000, 1,   1, 10);

    #12;
    check("reset.in_ready",  64'(bus.in_ready_o),    64'd1);
    check("reset.out_valid", 64'(bus.out_valid_o),   64'd0);
    check("reset.frame",     64'(bus.out_frame_o),   64'd0);
    check("reset.partial",   64'(bus.out_partial_o), 64'd0);
    check("reset.nbytes",    64'(bus.out_nbytes_o),  64'd0);
    check("reset.word_cnt",  64'(bus.word_cnt_o),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].v, vt[i].d, vt[i].f, vt[i].r);
      @(negedge clk);
      check($sformatf("row%0d.in_ready", i),  64'(bus.in_ready_o),    64'(vt[i].e_rdy));
      check($sformatf("row%0d.out_valid", i), 64'(bus.out_valid_o),   64'(vt[i].e_ov));
      check($sformatf("row%0d.word", i),      64'(bus.out_word_o),    64'(vt[i].e_word));
      check($sformatf("row%0d.frame", i),     64'(bus.out_frame_o),
            64'({5'b0, vt[i].e_word, 3'b0}));
      check($sformatf("row%0d.partial", i),   64'(bus.out_partial_o), 64'(vt[i].e_part));
      check($sformatf("row%0d.nbytes", i),    64'(bus.out_nbytes_o),  64'(vt[i].e_nb));
      check($sformatf("row%0d.word_cnt", i),  64'(bus.word_cnt_o),    64'(vt[i].e_cnt));
      check($sformatf("row%0d.cnt2_wrap", i), 64'(bus2.word_cnt_o),   64'(vt[i].e_cnt[1:0]));
      if (vt[i].e_nb != 3'd0)
        check($sformatf("row%0d.pad_word", i), 64'(bus2.out_word_o),
              64'(pad_word(vt[i].e_word, vt[i].e_nb, 8'hA5)));
      @(posedge clk); #1;
    end

    // Reset mid-word: a held output plus two queued bytes must vanish.
    drive(1'b1, 8'hA0, 1'b0, 1'b0); @(posedge clk); #1;
    drive(1'b1, 8'hA1, 1'b0, 1'b0); @(posedge clk); #1;
    drive(1'b1, 8'hA2, 1'b0, 1'b0); @(posedge clk); #1;
    drive(1'b1, 8'hA3, 1'b0, 1'b0); @(posedge clk); #1;
    drive(1'b1, 8'hE1, 1'b0, 1'b0); @(posedge clk); #1;
    drive(1'b1, 8'hE2, 1'b0, 1'b0); @(posedge clk); #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst.out_valid", 64'(bus.out_valid_o), 64'd1);
    check("pre_rst.word",      64'(bus.out_word_o),  64'hA0A1A2A3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.out_valid", 64'(bus.out_valid_o),   64'd0);
    check("async_rst.in_ready",  64'(bus.in_ready_o),    64'd1);
    check("async_rst.frame",     64'(bus.out_frame_o),   64'd0);
    check("async_rst.partial",   64'(bus.out_partial_o), 64'd0);
    check("async_rst.nbytes",    64'(bus.out_nbytes_o),  64'd0);
    check("async_rst.word_cnt",  64'(bus.word_cnt_o),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 8'h01, 1'b0, 1'b1); @(posedge clk); #1;
    drive(1'b1, 8'h02, 1'b0, 1'b1); @(posedge clk); #1;
    drive(1'b1, 8'h03, 1'b0, 1'b1); @(posedge clk); #1;
    drive(1'b1, 8'h04, 1'b0, 1'b1); @(posedge clk); #1;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check("post_rst.out_valid", 64'(bus.out_valid_o),   64'd1);
    check("post_rst.word",      64'(bus.out_word_o),    64'h01020304);
    check("post_rst.frame",     64'(bus.out_frame_o),   64'({5'b0, 32'h01020304, 3'b0}));
    check("post_rst.partial",   64'(bus.out_partial_o), 64'd0);
    check("post_rst.nbytes",    64'(bus.out_nbytes_o),  64'd4);
    check("post_rst.word_cnt",  64'(bus.word_cnt_o),    64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst.drain_valid", 64'(bus.out_valid_o), 64'd0);
    check("post_rst.cnt_after",   64'(bus.word_cnt_o),  64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
